// File: rtl/sync_fifo_rd_pkg.sv
// Shared constants and types for the synchronous FIFO stream reader.
//   RD_BUF_DEPTH       : entries in the reader's output buffer
//   rd_cnt_t           : occupancy count of that buffer (0..RD_BUF_DEPTH)
//   DEFAULT_DATA_WIDTH : default word width, matching the team FIFO default
package sync_fifo_rd_pkg;

  localparam int unsigned RD_BUF_DEPTH       = 3;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef logic [1:0] rd_cnt_t;

endpackage

// File: rtl/sync_fifo_rd_obuf.sv
// Small in-order output queue for the FIFO stream reader.
// Entry 0 is always the head, so the head word comes straight from a register.
// Slots at or above the count are kept at zero, so dout_o reads 0 when empty.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, din_i : write din_i at the tail this cycle
//   pop_i         : drop the head this cycle (ignored when empty)
//   dout_o        : head word
//   cnt_o         : number of valid entries
module sync_fifo_rd_obuf
  import sync_fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output rd_cnt_t               cnt_o
);

  logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RD_BUF_DEPTH];
  rd_cnt_t               cnt_q, cnt_d;
  rd_cnt_t               wr_idx;
  logic                  pop_ok;

  assign pop_ok = pop_i && (cnt_q != '0);
  // Tail slot after any pop this cycle has shifted the queue down.
  assign wr_idx = cnt_q - rd_cnt_t'(pop_ok);

  always_comb begin
    mem_d = mem_q;
    if (pop_ok) begin
      for (int i = 0; i < RD_BUF_DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[RD_BUF_DEPTH-1] = '0;
    end
    if (push_i) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        if (rd_cnt_t'(i) == wr_idx) begin
          mem_d[i] = din_i;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q + rd_cnt_t'(push_i) - rd_cnt_t'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign dout_o = mem_q[0];
  assign cnt_o  = cnt_q;

`ifndef SYNTHESIS
  // The reader's issue rule must never let a push land on a full queue.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_ok && (cnt_q == rd_cnt_t'(RD_BUF_DEPTH))));
`endif

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Read-side master for the team synchronous FIFO. Drains the FIFO and
// presents words on a valid/ready stream. A 3-entry output buffer hides the
// FIFO's one-cycle registered read, so one word per cycle is sustained and
// fifo_rd_en_o never depends on m_ready_i.
// Optional feature: define SYNC_FIFO_READER_LAST_EN to add m_last_o, which
// marks the final word of each PKT_LEN-word packet.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   en_i               : allows new FIFO reads
//   fifo_empty_i       : FIFO empty flag
//   fifo_underflow_i   : FIFO underflow pulse (another agent misread)
//   fifo_rdata_i       : FIFO read data, valid the cycle after a read
//   fifo_rd_en_o       : FIFO read request
//   m_valid_o/m_data_o : stream word, accepted when m_ready_i is high
//   rd_count_o         : words delivered, wrapping
//   err_o              : sticky underflow flag
//   m_last_o           : packet end marker (only with the optional feature)
module sync_fifo_stream_reader
  import sync_fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_underflow_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [CNT_WIDTH-1:0]  rd_count_o,
  output logic                  err_o
`ifdef SYNC_FIFO_READER_LAST_EN
  ,
  output logic                  m_last_o
`endif
);

  rd_cnt_t               buf_cnt;
  logic [DATA_WIDTH-1:0] buf_dout;
  logic [2:0]            occupancy;
  logic                  pop;

  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic                  err_q, err_d;

  // Buffered words plus the one still in flight must fit in the buffer.
  assign occupancy    = {1'b0, buf_cnt} + {2'b00, inflight_q};
  assign fifo_rd_en_o = en_i && !fifo_empty_i && (occupancy < 3'(RD_BUF_DEPTH));

  assign m_valid_o = (buf_cnt != '0);
  assign m_data_o  = buf_dout;
  assign pop       = m_valid_o && m_ready_i;

  sync_fifo_rd_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (inflight_q),
    .pop_i  (pop),
    .din_i  (fifo_rdata_i),
    .dout_o (buf_dout),
    .cnt_o  (buf_cnt)
  );

  always_comb begin
    inflight_d = fifo_rd_en_o;
    rd_count_d = rd_count_q + CNT_WIDTH'(pop);
    err_d      = err_q | fifo_underflow_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
      err_q      <= err_d;
    end
  end

  assign rd_count_o = rd_count_q;
  assign err_o      = err_q;

`ifdef SYNC_FIFO_READER_LAST_EN
  localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [BeatW-1:0] beat_q, beat_d;
  logic             beat_wrap;

  assign beat_wrap = (beat_q == BeatW'(PKT_LEN - 1));

  always_comb begin
    beat_d = beat_q;
    if (pop) begin
      beat_d = beat_wrap ? '0 : beat_q + BeatW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign m_last_o = m_valid_o && beat_wrap;
`endif

`ifndef SYNTHESIS
  a_pkt_len_min: assert property (@(posedge clk_i) PKT_LEN >= 1);
`endif

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
module tb_sync_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned PL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_underflow = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          err;
  logic [DW-1:0] fifo_rdata = '0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] rd_count;
`ifdef SYNC_FIFO_READER_LAST_EN
  logic          m_last;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural FIFO with registered read data.
  logic [DW-1:0] fifo_mem [64];
  int wp = 0;
  int rp = 0;

  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en && (wp != rp)) begin
      fifo_rdata <= fifo_mem[rp % 64];
      rp <= rp + 1;
    end
  end

  always #5 clk = ~clk;

  sync_fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .PKT_LEN    (PL)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .en_i             (en),
    .fifo_empty_i     (fifo_empty),
    .fifo_underflow_i (fifo_underflow),
    .fifo_rdata_i     (fifo_rdata),
    .fifo_rd_en_o     (fifo_rd_en),
    .m_valid_o        (m_valid),
    .m_data_o         (m_data),
    .m_ready_i        (m_ready),
    .rd_count_o       (rd_count),
    .err_o            (err)
`ifdef SYNC_FIFO_READER_LAST_EN
    ,
    .m_last_o         (m_last)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wp % 64] = first + DW'(i);
      wp = wp + 1;
    end
  endtask

  logic [DW-1:0] got_q [$];
  int pulses;

  initial begin
    // Reset with random inputs.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      en = 1'($urandom);
      m_ready = 1'($urandom);
      fifo_underflow = 1'($urandom);
      #1;
      check_eq($sformatf("rst_rd_en_%0d", c), 32'(fifo_rd_en), 32'd0);
      check_eq($sformatf("rst_valid_%0d", c), 32'(m_valid), 32'd0);
      check_eq($sformatf("rst_data_%0d", c), 32'(m_data), 32'd0);
      check_eq($sformatf("rst_count_%0d", c), 32'(rd_count), 32'd0);
      check_eq($sformatf("rst_err_%0d", c), 32'(err), 32'd0);
    end
    @(negedge clk);
    fifo_underflow = 1'b0;
    en = 1'b1;
    m_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("empty_no_rd_%0d", c), 32'(fifo_rd_en), 32'd0);
    end

    // Streaming: rd_en cycles 0-3, valid cycles 2-5 with 0x11..0x14.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) preload(8'h11, 4);
      #1;
      check_eq($sformatf("stream_rd_en_c%0d", c), 32'(fifo_rd_en), 32'(c <= 3));
      check_eq($sformatf("stream_valid_c%0d", c), 32'(m_valid), 32'(c >= 2 && c <= 5));
      check_eq($sformatf("stream_data_c%0d", c), 32'(m_data),
               (c >= 2 && c <= 5) ? 32'(8'h11 + c - 2) : 32'd0);
    end
    check_eq("stream_count", 32'(rd_count), 32'd4);

    // Backpressure: only 3 words pulled, head holds.
    m_ready = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) preload(8'h21, 5);
      #1;
      pulses += int'(fifo_rd_en);
    end
    check_eq("bp_pulses", 32'(pulses), 32'd3);
    check_eq("bp_valid", 32'(m_valid), 32'd1);
    check_eq("bp_head", 32'(m_data), 32'h21);
    check_eq("bp_fifo_left", 32'(wp - rp), 32'd2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      check_eq($sformatf("bp_valid_c%0d", c), 32'(m_valid), 32'(c <= 4));
      check_eq($sformatf("bp_data_c%0d", c), 32'(m_data),
               (c <= 4) ? 32'(8'h21 + c) : 32'd0);
    end
    check_eq("bp_count", 32'(rd_count), 32'd9);

    // Enable drop after the second read.
    pulses = 0;
    got_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) preload(8'h31, 8);
      if (c == 2) en = 1'b0;
      #1;
      pulses += int'(fifo_rd_en);
      if (m_valid && m_ready) got_q.push_back(m_data);
    end
    check_eq("endrop_pulses", 32'(pulses), 32'd2);
    check_eq("endrop_words", 32'(got_q.size()), 32'd2);
    check_eq("endrop_fifo_left", 32'(wp - rp), 32'd6);
    for (int i = 0; i < 2 && i < got_q.size(); i++)
      check_eq($sformatf("endrop_w%0d", i), 32'(got_q[i]), 32'(8'h31 + i));
    got_q.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      en = 1'b1;
      #1;
      if (m_valid && m_ready) got_q.push_back(m_data);
    end
    check_eq("enret_words", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      check_eq($sformatf("enret_w%0d", i), 32'(got_q[i]), 32'(8'h33 + i));
    check_eq("enret_count", 32'(rd_count), 32'd17);

    // Sticky error.
    @(negedge clk);
    fifo_underflow = 1'b1;
    #1;
    check_eq("err_before", 32'(err), 32'd0);
    @(negedge clk);
    fifo_underflow = 1'b0;
    #1;
    check_eq("err_set", 32'(err), 32'd1);
    repeat (20) @(negedge clk);
    #1;
    check_eq("err_held", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("err_cleared", 32'(err), 32'd0);
    check_eq("count_cleared", 32'(rd_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SYNC_FIFO_READER_LAST_EN
    // Packet marker on words 4 and 8.
    got_q.delete();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) preload(8'h41, 8);
      #1;
      if (m_valid && m_ready) begin
        check_eq($sformatf("last_w%0d", got_q.size()), 32'(m_last),
                 32'(got_q.size() == 3 || got_q.size() == 7));
        got_q.push_back(m_data);
      end
    end
    check_eq("last_words", 32'(got_q.size()), 32'd8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
